// File: rtl/life_if.sv
// life_if: control/map bundle between the Game-of-Life scheduler and its controller.
interface life_if #(parameter int W = 16, parameter int H = 16, parameter int CW = 16);
    localparam int N  = W * H;
    localparam int IW = $clog2(N);
    localparam int PW = $clog2(N + 1);
    logic          run;
    logic          step_tick;
    logic          step_req;
    logic          load_req;
    logic [N-1:0]  load_map;
    logic          load_ack;
    logic          toggle_req;
    logic [IW-1:0] toggle_idx;
    logic          toggle_ack;
    logic [N-1:0]  map;
    logic          busy;
    logic          gen_done;
    logic [CW-1:0] gen_count;
    logic [PW-1:0] pop_count;
    logic          overrun;
    modport master (
        output run, step_tick, step_req, load_req, load_map, toggle_req, toggle_idx,
        input  load_ack, toggle_ack, map, busy, gen_done, gen_count, pop_count, overrun
    );
    modport slave (
        input  run, step_tick, step_req, load_req, load_map, toggle_req, toggle_idx,
        output load_ack, toggle_ack, map, busy, gen_done, gen_count, pop_count, overrun
    );
endinterface

// File: rtl/life_step_scheduler.sv
// life_step_scheduler: owns the torus map, arbitrates load/toggle/step, computes B3/S23 one row per cycle.
module life_step_scheduler #(
    parameter int W  = 16,
    parameter int H  = 16,
    parameter int CW = 16
) (
    input logic   clk,
    input logic   rst,
    life_if.slave b
);
    localparam int N  = W * H;
    localparam int RW = $clog2(H);
    localparam int PW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
    state_t        state_q, state_d;
    logic [N-1:0]  map_q, map_d, nxt_q, nxt_d;
    logic [RW-1:0] row_q, row_d, row_up, row_dn;
    logic [PW-1:0] acc_q, acc_d, pop_q, pop_d, row_pop;
    logic [CW-1:0] gen_q, gen_d;
    logic          pend_q, pend_d, ovr_q, ovr_d;
    logic [W-1:0]  up, cur, dn, new_row;
    logic [3:0]    n;
    logic          trig, start, load_ack, toggle_ack, gen_done;
    assign trig   = b.run ? b.step_tick : b.step_req;
    assign row_up = (row_q == '0) ? RW'(H - 1) : row_q - RW'(1);
    assign row_dn = (row_q == RW'(H - 1)) ? '0 : row_q + RW'(1);
    assign up     = map_q[int'(row_up) * W +: W];
    assign cur    = map_q[int'(row_q) * W +: W];
    assign dn     = map_q[int'(row_dn) * W +: W];
    // neighbour columns wrap around the torus edges
    always_comb begin
        new_row = '0;
        row_pop = '0;
        n       = '0;
        for (int x = 0; x < W; x++) begin
            n = 4'(up[(x + W - 1) % W]) + 4'(up[x]) + 4'(up[(x + 1) % W])
              + 4'(cur[(x + W - 1) % W]) + 4'(cur[(x + 1) % W])
              + 4'(dn[(x + W - 1) % W]) + 4'(dn[x]) + 4'(dn[(x + 1) % W]);
            new_row[x] = (n == 4'd3) | (cur[x] & (n == 4'd2));
            row_pop    = row_pop + PW'(new_row[x]);
        end
    end
    always_comb begin
        state_d    = state_q;
        map_d      = map_q;
        nxt_d      = nxt_q;
        row_d      = row_q;
        acc_d      = acc_q;
        pop_d      = pop_q;
        gen_d      = gen_q;
        pend_d     = pend_q;
        ovr_d      = ovr_q;
        load_ack   = 1'b0;
        toggle_ack = 1'b0;
        gen_done   = 1'b0;
        start      = 1'b0;
        if (b.load_req) begin
            map_d    = b.load_map;
            load_ack = 1'b1;
            pend_d   = 1'b0;
            state_d  = IDLE;
        end else if (state_q == IDLE) begin
            if (b.toggle_req) begin
                map_d[b.toggle_idx] = ~map_q[b.toggle_idx];
                toggle_ack          = 1'b1;
            end else if (trig | pend_q) begin
                start   = 1'b1;
                state_d = SCAN;
                row_d   = '0;
                acc_d   = '0;
                pend_d  = 1'b0;
            end
        end else if (state_q == SCAN) begin
            nxt_d[int'(row_q) * W +: W] = new_row;
            acc_d   = acc_q + row_pop;
            row_d   = (row_q == RW'(H - 1)) ? '0 : row_q + RW'(1);
            state_d = (row_q == RW'(H - 1)) ? COMMIT : SCAN;
        end else begin
            map_d    = nxt_q;
            gen_d    = gen_q + CW'(1);
            pop_d    = acc_q;
            gen_done = 1'b1;
            state_d  = IDLE;
        end
        // a load discards any waiting step, but a second lost trigger is still an overrun
        if (trig & ~start) begin
            pend_d = ~b.load_req | pend_d;
            ovr_d  = ovr_q | pend_q;
        end
        if (rst) begin
            load_ack   = 1'b0;
            toggle_ack = 1'b0;
            gen_done   = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            map_q   <= '0;
            nxt_q   <= '0;
            row_q   <= '0;
            acc_q   <= '0;
            pop_q   <= '0;
            gen_q   <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            nxt_q   <= nxt_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            pop_q   <= pop_d;
            gen_q   <= gen_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end
    assign b.load_ack   = load_ack;
    assign b.toggle_ack = toggle_ack;
    assign b.gen_done   = gen_done;
    assign b.map        = map_q;
    assign b.busy       = state_q != IDLE;
    assign b.gen_count  = gen_q;
    assign b.pop_count  = pop_q;
    assign b.overrun    = ovr_q;
endmodule

// File: tb/tb_life_step_scheduler.sv
// tb_life_step_scheduler: directed checks of load/toggle/step arbitration and B3/S23 generations.
module tb_life_step_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;
    logic [255:0] blink_h, blink_v, glider, exp_m;
    life_if #(.W(16), .H(16), .CW(16)) bus ();
    life_step_scheduler #(.W(16), .H(16), .CW(16)) dut (.clk(clk), .rst(rst), .b(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [255:0] m);
        bus.load_req = 1'b1;
        bus.load_map = m;
        @(negedge clk);
        chk(tag, 256'(bus.load_ack), 256'(1));
        cyc();
        bus.load_req = 1'b0;
    endtask

    task automatic do_step(output int busy_cyc, output int gd_at);
        bus.step_req = 1'b1;
        cyc();
        bus.step_req = 1'b0;
        busy_cyc = 0;
        gd_at    = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.gen_done) gd_at = busy_cyc + 1;
            if (!bus.busy) break;
            busy_cyc++;
            cyc();
        end
        cyc();
    endtask

    task automatic wait_gen_done(input string tag);
        int seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.gen_done) begin
                seen = 1;
                break;
            end
        end
        chk(tag, 256'(seen), 256'(1));
        cyc();
    endtask

    initial begin
        int bc, gd, ta;
        blink_h = '0; blink_h[84] = 1'b1; blink_h[85] = 1'b1; blink_h[86] = 1'b1;
        blink_v = '0; blink_v[69] = 1'b1; blink_v[85] = 1'b1; blink_v[101] = 1'b1;
        glider  = '0; glider[1] = 1'b1; glider[18] = 1'b1; glider[32] = 1'b1; glider[33] = 1'b1; glider[34] = 1'b1;
        bus.run = 1'b0; bus.step_tick = 1'b0; bus.step_req = 1'b0;
        bus.load_req = 1'b0; bus.load_map = '0; bus.toggle_req = 1'b0; bus.toggle_idx = '0;
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_map", bus.map, '0);
        chk("rst_outs", 256'({bus.busy, bus.gen_done, bus.load_ack, bus.toggle_ack, bus.overrun}), '0);
        chk("rst_counts", 256'({bus.gen_count, bus.pop_count}), '0);
        cyc();

        // blinker: one generation
        do_load("t1_load_ack", blink_h);
        chk("t1_loaded", bus.map, blink_h);
        do_step(bc, gd);
        chk("t1_busy_cycles", 256'(bc), 256'(17));
        chk("t1_gen_done_at", 256'(gd), 256'(17));
        chk("t1_map", bus.map, blink_v);
        chk("t1_pop", 256'(bus.pop_count), 256'(3));
        chk("t1_gen", 256'(bus.gen_count), 256'(1));

        // glider wraps the torus after 64 generations
        do_reset();
        do_load("t2_load_ack", glider);
        for (int g = 0; g < 64; g++) begin
            do_step(bc, gd);
            chk($sformatf("t2_pop_g%0d", g + 1), 256'(bus.pop_count), 256'(5));
        end
        chk("t2_map", bus.map, glider);
        chk("t2_gen", 256'(bus.gen_count), 256'(64));

        // toggle raised mid-scan waits for the idle cycle after commit
        do_reset();
        do_load("t3_load_ack", blink_h);
        bus.step_req = 1'b1;
        cyc();
        bus.step_req = 1'b0;
        repeat (3) cyc();
        bus.toggle_req = 1'b1;
        bus.toggle_idx = '0;
        gd = -1;
        ta = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.gen_done) gd = i;
            if (bus.toggle_ack) begin
                ta = i;
                break;
            end
            cyc();
        end
        chk("t3_ack_after_gd", 256'(ta - gd), 256'(1));
        chk("t3_gd_row", 256'(gd), 256'(13));
        cyc();
        bus.toggle_req = 1'b0;
        exp_m = blink_v;
        exp_m[0] = 1'b1;
        chk("t3_map", bus.map, exp_m);
        chk("t3_gen", 256'(bus.gen_count), 256'(1));

        // load aborts a generation in progress
        do_reset();
        do_load("t4_load0_ack", blink_h);
        bus.step_req = 1'b1;
        cyc();
        bus.step_req = 1'b0;
        repeat (8) cyc();
        bus.load_req = 1'b1;
        bus.load_map = glider;
        @(negedge clk);
        chk("t4_ack", 256'(bus.load_ack), 256'(1));
        chk("t4_no_gd", 256'(bus.gen_done), 256'(0));
        cyc();
        bus.load_req = 1'b0;
        chk("t4_busy", 256'(bus.busy), 256'(0));
        chk("t4_map", bus.map, glider);
        chk("t4_gen", 256'(bus.gen_count), 256'(0));
        repeat (20) begin
            @(negedge clk);
            if (bus.gen_done || bus.busy) chk("t4_stays_idle", 256'({bus.gen_done, bus.busy}), '0);
            cyc();
        end
        chk("t4_map_later", bus.map, glider);

        // overrun from rate ticks every other cycle
        do_reset();
        do_load("t5_load_ack", blink_h);
        bus.run = 1'b1;
        bus.step_tick = 1'b1;
        cyc();
        bus.step_tick = 1'b0;
        chk("t5_busy", 256'(bus.busy), 256'(1));
        cyc();
        bus.step_tick = 1'b1;
        cyc();
        bus.step_tick = 1'b0;
        chk("t5_ovr_after_t2", 256'(bus.overrun), 256'(0));
        cyc();
        bus.step_tick = 1'b1;
        cyc();
        bus.step_tick = 1'b0;
        chk("t5_ovr_after_t4", 256'(bus.overrun), 256'(1));
        wait_gen_done("t5_gd1_seen");
        chk("t5_idle_after_commit", 256'(bus.busy), 256'(0));
        chk("t5_gen1", 256'(bus.gen_count), 256'(1));
        chk("t5_map1", bus.map, blink_v);
        cyc();
        chk("t5_gen2_started", 256'(bus.busy), 256'(1));
        wait_gen_done("t5_gd2_seen");
        chk("t5_gen2", 256'(bus.gen_count), 256'(2));
        chk("t5_map2", bus.map, blink_h);
        chk("t5_ovr_sticky", 256'(bus.overrun), 256'(1));
        bus.run = 1'b0;

        // reset in the middle of a scan
        bus.step_req = 1'b1;
        cyc();
        bus.step_req = 1'b0;
        repeat (8) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_map", bus.map, '0);
        chk("t6_busy", 256'(bus.busy), 256'(0));
        chk("t6_gen", 256'(bus.gen_count), 256'(0));
        chk("t6_ovr", 256'(bus.overrun), 256'(0));
        chk("t6_pop", 256'(bus.pop_count), 256'(0));
        do_step(bc, gd);
        chk("t6_empty_map", bus.map, '0);
        chk("t6_empty_pop", 256'(bus.pop_count), 256'(0));
        chk("t6_empty_gen", 256'(bus.gen_count), 256'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
